alu_seq: RTL

Parametrised, multi-cycle successor to the datapath ALU. It accepts one operation per valid/ready handshake and executes ADD/SUB/logic ops in one cycle. Shifts run iteratively at one bit per cycle, and unsigned multiply runs as shift-add over WIDTH cycles. Result and a 4-bit flag vector are held registered until the control unit takes them.

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: one-cycle arithmetic/logic, bit-serial shifts, shift-add unsigned multiply.
// Result, high product word and flags are held until the consumer takes them.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       fun,
  input  logic [WIDTH-1:0] Ry,
  input  logic [WIDTH-1:0] Rx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_hi,
  output logic [3:0]       band
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [WIDTH:0] NMAX = (WIDTH + 1)'(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_ASR = 4'd9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       fun_q, fun_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       band_q, band_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   sum, diff, madd;
  logic [CW-1:0]    nsh;
  logic             c, v;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign Result    = lo_q;
  assign Result_hi = hi_q;
  assign band      = band_q;

  always_comb begin
    state_d = state_q;
    fun_d   = fun_q;
    opb_d   = opb_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    band_d  = band_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, Ry} + {1'b0, Rx};
    diff    = {1'b0, Ry} - {1'b0, Rx};
    madd    = '0;
    c       = 1'b0;
    v       = 1'b0;
    nsh     = ({1'b0, Rx} > NMAX) ? CW'(WIDTH + 1) : CW'(Rx);

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          fun_d   = fun;
          opb_d   = Rx;
          hi_d    = '0;
          state_d = DONE;
          case (fun)
            OP_ADD: begin
              lo_d = sum[WIDTH-1:0];
              c    = sum[WIDTH];
              v    = (Ry[WIDTH-1] == Rx[WIDTH-1]) && (sum[WIDTH-1] != Ry[WIDTH-1]);
            end
            OP_SUB: begin
              lo_d = diff[WIDTH-1:0];
              c    = diff[WIDTH];
              v    = (Ry[WIDTH-1] != Rx[WIDTH-1]) && (diff[WIDTH-1] != Ry[WIDTH-1]);
            end
            OP_SHL, OP_SHR, OP_ASR: begin
              lo_d  = Ry;
              cnt_d = nsh;
              if (nsh != '0) state_d = BUSY;
            end
            OP_NOT:  lo_d = ~Rx;
            OP_AND:  lo_d = Ry & Rx;
            OP_OR:   lo_d = Ry | Rx;
            OP_XOR:  lo_d = Ry ^ Rx;
            OP_MUL: begin
              lo_d    = Ry;
              cnt_d   = CW'(WIDTH);
              state_d = BUSY;
            end
            default: lo_d = '0;
          endcase
          band_d = {v, c, lo_d[WIDTH-1], lo_d == '0};
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
        if (fun_q == OP_MUL) begin
          // Multiplier sits in lo and drains out the bottom as the product fills in from the top.
          madd   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opb_q}) : {1'b0, hi_q};
          hi_d   = madd[WIDTH:1];
          lo_d   = {madd[0], lo_q[WIDTH-1:1]};
          band_d = {1'b0, |hi_d, lo_d[WIDTH-1], lo_d == '0};
        end else begin
          case (fun_q)
            OP_SHL: begin
              c    = lo_q[WIDTH-1];
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            OP_ASR: begin
              c    = lo_q[0];
              lo_d = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
            end
            default: begin
              c    = lo_q[0];
              lo_d = {1'b0, lo_q[WIDTH-1:1]};
            end
          endcase
          band_d = {1'b0, c, lo_d[WIDTH-1], lo_d == '0};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fun_q   <= '0;
      opb_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      band_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fun_q   <= fun_d;
      opb_q   <= opb_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      band_q  <= band_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
